// File: rtl/i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arbiter
// Description : Round-robin arbiter that lets NUM_REQ requesters share a
//               single i2c_controller. The winner's 24-bit frame
//               {device address, register word} is latched at grant time
//               and re-issued up to MAX_RETRY extra times after a NACK.
//               The requester then gets a one-cycle done (ACK) or nack
//               (retries exhausted) pulse on its grant bit.
//
// Ports       : clk            - sole clock, rising edge
//               rst_n          - asynchronous active-low reset
//               req            - per-requester request level
//               req_data       - per-requester frame, slot i at [24i+23:24i]
//               gnt            - one-hot grant, zero when idle
//               done / nack    - one-cycle completion pulses on the grant bit
//               busy           - arbiter is not idle
//               transfer_start - start level to the controller
//               transfer_data  - latched frame to the controller
//               transfer_end   - completion level from the controller
//               transfer_ack_n - controller ACK status (1 = NACK)
//
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [24*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      nack,
    output logic                    busy,
    output logic                    transfer_start,
    output logic [23:0]             transfer_data,
    input  logic                    transfer_end,
    input  logic                    transfer_ack_n
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_rty_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_xfer = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;

    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_rty_w-1:0] c_max_rty  = c_rty_w'(MAX_RETRY);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_nack;
    logic                r_busy;
    logic                r_start;
    logic [23:0]         r_data;
    logic [c_rty_w-1:0]  r_retry;
    logic                r_retry_pend;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  r_last;

    // ------------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------------
    // (base + k) mod NUM_REQ; base < NUM_REQ and k <= NUM_REQ, so a single
    // conditional subtraction is enough.
    function automatic logic [c_idx_w-1:0] f_wrap_add(
        input logic [c_idx_w-1:0] base,
        input int                 k
    );
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return c_idx_w'(sum);
    endfunction

    logic [c_idx_w-1:0]  w_sel_idx;
    logic                w_sel_vld;
    logic [NUM_REQ-1:0]  w_sel_oh;
    logic [23:0]         w_sel_data;
    logic                w_can_retry;

    // Walk the candidates from farthest to nearest so that the nearest set
    // request after last_grant is the one left standing.
    always_comb begin
        w_sel_idx = r_last;
        w_sel_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[f_wrap_add(r_last, k)]) begin
                w_sel_idx = f_wrap_add(r_last, k);
                w_sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_oh            = '0;
        w_sel_oh[w_sel_idx] = 1'b1;
    end

    assign w_sel_data  = req_data[24*w_sel_idx +: 24];
    assign w_can_retry = (r_retry < c_max_rty);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_gnt        <= '0;
            r_done       <= '0;
            r_nack       <= '0;
            r_busy       <= 1'b0;
            r_start      <= 1'b0;
            r_data       <= '0;
            r_retry      <= '0;
            r_retry_pend <= 1'b0;
            r_idx        <= '0;
            r_last       <= c_last_rst;
        end else begin
            // done/nack are single-cycle pulses: only the XFER exit sets them.
            r_done <= '0;
            r_nack <= '0;

            case (r_state)
                c_st_idle: begin
                    if (w_sel_vld) begin
                        r_state      <= c_st_xfer;
                        r_busy       <= 1'b1;
                        r_gnt        <= w_sel_oh;
                        r_idx        <= w_sel_idx;
                        r_data       <= w_sel_data;
                        r_retry      <= '0;
                        r_retry_pend <= 1'b0;
                        r_start      <= 1'b1;
                    end
                end

                c_st_xfer: begin
                    if (transfer_end) begin
                        r_state <= c_st_gap;
                        r_start <= 1'b0;
                        if (!transfer_ack_n) begin
                            r_done       <= r_gnt;
                            r_retry_pend <= 1'b0;
                        end else if (w_can_retry) begin
                            r_retry      <= r_retry + 1'b1;
                            r_retry_pend <= 1'b1;
                        end else begin
                            r_nack       <= r_gnt;
                            r_retry_pend <= 1'b0;
                        end
                    end
                end

                c_st_gap: begin
                    // Wait for the controller to drop its end level before
                    // either re-issuing the same frame or releasing the bus.
                    if (!transfer_end) begin
                        if (r_retry_pend) begin
                            r_state      <= c_st_xfer;
                            r_start      <= 1'b1;
                            r_retry_pend <= 1'b0;
                        end else begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                            r_gnt   <= '0;
                            r_last  <= r_idx;
                        end
                    end
                end

                default: begin
                    r_state      <= c_st_idle;
                    r_busy       <= 1'b0;
                    r_gnt        <= '0;
                    r_start      <= 1'b0;
                    r_retry_pend <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------------
    assign gnt            = r_gnt;
    assign done           = r_done;
    assign nack           = r_nack;
    assign busy           = r_busy;
    assign transfer_start = r_start;
    assign transfer_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_arbiter
// Description : Self-checking bench for i2c_arbiter (NUM_REQ=4,
//               MAX_RETRY=3): a vector table for the basic handshake,
//               directed sequences for arbitration order, retry/NACK,
//               early request drop and mid-transfer reset, then random
//               traffic checked against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [95:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  nack;
    logic        busy;
    logic        transfer_start;
    logic [23:0] transfer_data;
    logic        transfer_end;
    logic        transfer_ack_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_data       (req_data),
        .gnt            (gnt),
        .done           (done),
        .nack           (nack),
        .busy           (busy),
        .transfer_start (transfer_start),
        .transfer_data  (transfer_data),
        .transfer_end   (transfer_end),
        .transfer_ack_n (transfer_ack_n)
    );

    // Pulse/edge counters sampled on the falling edge.
    int   start_rises = 0;
    int   done_pulses = 0;
    int   nack_pulses = 0;
    logic start_q     = 1'b0;

    always @(negedge clk) begin
        if (transfer_start && !start_q) start_rises++;
        if (done != 4'b0) done_pulses++;
        if (nack != 4'b0) nack_pulses++;
        start_q = transfer_start;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        req            = '0;
        req_data       = '0;
        transfer_end   = 1'b0;
        transfer_ack_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Plays the controller for one attempt: waits (bounded) for a start,
    // answers with the given ack_n, reports grant/data seen and the pulses
    // that follow, and drops the served requester's req on done/nack.
    task automatic serve(input logic ack_n, output logic [3:0] g, output logic [23:0] dat,
                         output logic [3:0] d, output logic [3:0] n);
        int k;
        k = 0;
        while (transfer_start !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("serve_start_seen", transfer_start, 1);
        g              = gnt;
        dat            = transfer_data;
        transfer_end   = 1'b1;
        transfer_ack_n = ack_n;
        tick();
        d = done;
        n = nack;
        chk("serve_start_drop", transfer_start, 0);
        req          = req & ~(d | n);
        transfer_end = 1'b0;
        tick();
    endtask

    // Round robin by definition: first set bit at last+1, last+2, ... mod N.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  req;
        logic [23:0] slot2;
        logic        te;
        logic        ack_n;
        logic [3:0]  e_gnt;
        logic        e_start;
        logic [23:0] e_data;
        logic [3:0]  e_done;
        logic [3:0]  e_nack;
        logic        e_busy;
    } vec_t;

    vec_t        tbl[6];
    logic [3:0]  g, d, n;
    logic [23:0] dat;
    int          b_rise, b_done, b_nack;

    // Reference model state for the random phase
    logic [3:0]  req_in, p_gnt;
    logic [95:0] slot_in;
    logic        te_in, ack_in, p_start, m_pending;
    int          m_last, m_idx, m_attempts, e;
    logic [23:0] m_data;

    initial begin
        // ---------------- Reset state ----------------
        rst_n = 1'b0; req = '0; req_data = '0; transfer_end = 1'b0; transfer_ack_n = 1'b0;
        repeat (2) tick();
        chk("rst_gnt",   gnt, 0);
        chk("rst_done",  done, 0);
        chk("rst_nack",  nack, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_start", transfer_start, 0);
        chk("rst_data",  transfer_data, 0);
        rst_n = 1'b1;

        // ---------------- Vector table: single ACKed transfer ----------------
        tbl[0] = '{4'b0100, 24'h341E00, 1'b0, 1'b0, 4'b0100, 1'b1, 24'h341E00, 4'b0000, 4'b0000, 1'b1};
        tbl[1] = '{4'b0100, 24'hABCDEF, 1'b0, 1'b0, 4'b0100, 1'b1, 24'h341E00, 4'b0000, 4'b0000, 1'b1};
        tbl[2] = '{4'b0100, 24'hABCDEF, 1'b1, 1'b0, 4'b0100, 1'b0, 24'h341E00, 4'b0100, 4'b0000, 1'b1};
        tbl[3] = '{4'b0000, 24'hABCDEF, 1'b1, 1'b0, 4'b0100, 1'b0, 24'h341E00, 4'b0000, 4'b0000, 1'b1};
        tbl[4] = '{4'b0000, 24'hABCDEF, 1'b0, 1'b0, 4'b0000, 1'b0, 24'h341E00, 4'b0000, 4'b0000, 1'b0};
        tbl[5] = '{4'b0000, 24'h123456, 1'b0, 1'b0, 4'b0000, 1'b0, 24'h341E00, 4'b0000, 4'b0000, 1'b0};
        for (int i = 0; i < 6; i++) begin
            req             = tbl[i].req;
            req_data[71:48] = tbl[i].slot2;
            transfer_end    = tbl[i].te;
            transfer_ack_n  = tbl[i].ack_n;
            tick();
            chk($sformatf("t%0d_gnt", i),   gnt,            tbl[i].e_gnt);
            chk($sformatf("t%0d_start", i), transfer_start, tbl[i].e_start);
            chk($sformatf("t%0d_data", i),  transfer_data,  tbl[i].e_data);
            chk($sformatf("t%0d_done", i),  done,           tbl[i].e_done);
            chk($sformatf("t%0d_nack", i),  nack,           tbl[i].e_nack);
            chk($sformatf("t%0d_busy", i),  busy,           tbl[i].e_busy);
        end

        // ---------------- Round-robin order ----------------
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, g, dat, d, n);
            chk($sformatf("rr%0d_gnt", i),  g, 4'b0001 << i);
            chk($sformatf("rr%0d_done", i), d, 4'b0001 << i);
        end
        chk("rr_idle_gnt", gnt, 0);
        req = 4'b1001;
        serve(1'b0, g, dat, d, n);
        chk("rr_1001_first", g, 4'b0001);
        serve(1'b0, g, dat, d, n);
        chk("rr_1001_second", g, 4'b1000);

        // ---------------- NACK on every attempt ----------------
        apply_reset();
        b_rise = start_rises; b_done = done_pulses; b_nack = nack_pulses;
        req = 4'b0001;
        req_data[23:0] = 24'h5A17C3;
        for (int i = 0; i < 4; i++) begin
            serve(1'b1, g, dat, d, n);
            chk($sformatf("nk%0d_data", i), dat, 24'h5A17C3);
            chk($sformatf("nk%0d_nack", i), n, (i == 3) ? 4'b0001 : 4'b0000);
            chk($sformatf("nk%0d_done", i), d, 0);
        end
        repeat (3) tick();
        chk("nk_start_rises", start_rises - b_rise, 4);
        chk("nk_nack_pulses", nack_pulses - b_nack, 1);
        chk("nk_done_pulses", done_pulses - b_done, 0);
        chk("nk_idle_gnt", gnt, 0);

        // ---------------- NACK then ACK ----------------
        apply_reset();
        b_rise = start_rises; b_done = done_pulses; b_nack = nack_pulses;
        req = 4'b0010;
        req_data[47:24] = 24'h2C0A55;
        serve(1'b1, g, dat, d, n);
        chk("na_first_pulse", d | n, 0);
        serve(1'b0, g, dat, d, n);
        chk("na_data", dat, 24'h2C0A55);
        chk("na_done", d, 4'b0010);
        repeat (2) tick();
        chk("na_start_rises", start_rises - b_rise, 2);
        chk("na_done_pulses", done_pulses - b_done, 1);
        chk("na_nack_pulses", nack_pulses - b_nack, 0);

        // ---------------- Granted requester drops req mid-transfer ----------------
        apply_reset();
        req = 4'b1000;
        tick();
        chk("drop_gnt", gnt, 4'b1000);
        req = 4'b0000;
        tick();
        serve(1'b0, g, dat, d, n);
        chk("drop_done", d, 4'b1000);
        repeat (3) tick();
        chk("drop_no_regrant", gnt, 0);
        chk("drop_no_start", transfer_start, 0);

        // ---------------- Reset during XFER ----------------
        apply_reset();
        req = 4'b0100;
        req_data[71:48] = 24'h00BEEF;
        tick();
        chk("rx_start_before", transfer_start, 1);
        b_done = done_pulses; b_nack = nack_pulses;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rx_start_async", transfer_start, 0);
        chk("rx_gnt_async",   gnt, 0);
        chk("rx_busy_async",  busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rx_regrant", gnt, 4'b0100);
        chk("rx_restart", transfer_start, 1);
        chk("rx_data",    transfer_data, 24'h00BEEF);
        chk("rx_no_pulse", (done_pulses - b_done) + (nack_pulses - b_nack), 0);
        serve(1'b0, g, dat, d, n);

        // ---------------- Random traffic vs reference model ----------------
        apply_reset();
        m_last = NUM_REQ - 1; m_idx = 0; m_attempts = 0; m_pending = 1'b0; m_data = '0;
        p_gnt = '0; p_start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && (done[i] || nack[i])) begin
                    req[i] = 1'b0;
                end else if (!req[i] && !gnt[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req[i] = 1'b1;
                        req_data[24*i +: 24] = 24'($urandom);
                    end
                end else if (req[i] && gnt[i]) begin
                    if ($urandom_range(15) == 0) req_data[24*i +: 24] = 24'($urandom);
                    if ($urandom_range(31) == 0) req[i] = 1'b0;
                end
            end
            if (!transfer_end) begin
                if (transfer_start && $urandom_range(2) == 0) begin
                    transfer_end   = 1'b1;
                    transfer_ack_n = ($urandom_range(1) == 0);
                end
            end else if (!transfer_start) begin
                if ($urandom_range(1) == 0) transfer_end = 1'b0;
            end

            req_in = req; slot_in = req_data; te_in = transfer_end; ack_in = transfer_ack_n;
            tick();

            chk("inv_onehot",    32'($onehot0(gnt)), 1);
            chk("inv_done_gnt",  done & ~gnt, 0);
            chk("inv_nack_gnt",  nack & ~gnt, 0);
            chk("inv_done_nack", done & nack, 0);
            chk("inv_busy",      busy, (gnt != 4'b0));

            if (p_gnt == 4'b0) begin
                chk("idle_done", done, 0);
                chk("idle_nack", nack, 0);
                if (req_in != 4'b0) begin
                    e = rr_pick(req_in, m_last);
                    chk("rnd_grant", gnt, 4'b0001 << e);
                    chk("rnd_grant_start", transfer_start, 1);
                    chk("rnd_grant_data", transfer_data, slot_in[24*e +: 24]);
                    m_idx = e; m_attempts = 1; m_pending = 1'b0;
                    m_data = slot_in[24*e +: 24];
                end else begin
                    chk("idle_gnt", gnt, 0);
                    chk("idle_start", transfer_start, 0);
                end
            end else if (p_start) begin
                chk("xfer_gnt_hold", gnt, p_gnt);
                chk("xfer_data_hold", transfer_data, m_data);
                if (te_in) begin
                    chk("xfer_end_start", transfer_start, 0);
                    if (!ack_in) begin
                        chk("xfer_ack_done", done, p_gnt);
                        chk("xfer_ack_nack", nack, 0);
                    end else if (m_attempts <= MAX_RETRY) begin
                        chk("xfer_retry_done", done, 0);
                        chk("xfer_retry_nack", nack, 0);
                        m_pending = 1'b1;
                    end else begin
                        chk("xfer_giveup_done", done, 0);
                        chk("xfer_giveup_nack", nack, p_gnt);
                    end
                end else begin
                    chk("xfer_wait_start", transfer_start, 1);
                    chk("xfer_wait_pulse", done | nack, 0);
                end
            end else begin
                chk("gap_pulse", done | nack, 0);
                chk("gap_data", transfer_data, m_data);
                if (te_in) begin
                    chk("gap_hold_gnt", gnt, p_gnt);
                    chk("gap_hold_start", transfer_start, 0);
                end else if (m_pending) begin
                    chk("gap_retry_gnt", gnt, p_gnt);
                    chk("gap_retry_start", transfer_start, 1);
                    m_attempts++;
                    m_pending = 1'b0;
                end else begin
                    chk("gap_release_gnt", gnt, 0);
                    chk("gap_release_start", transfer_start, 0);
                    m_last = m_idx;
                end
            end
            p_gnt   = gnt;
            p_start = transfer_start;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of requesters sharing one i2c_controller.
REQ-002 Parameter MAX_RETRY, default 3, sets the re-issues allowed after a NACK before giving up.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester request level; held high until that requester's done or nack.
REQ-006 req_data  input  24*NUM_REQ  per-requester {device address, 16-bit register word}; slot i occupies bits [24i+23:24i].
REQ-007 gnt  output  NUM_REQ  one-hot grant, all-zero when idle.
REQ-008 done  output  NUM_REQ  one-cycle pulse on the granted bit: transfer completed with ACK.
REQ-009 nack  output  NUM_REQ  one-cycle pulse on the granted bit: transfer NACKed after retries exhausted.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 transfer_start  output  1  start level to i2c_controller.
REQ-012 transfer_data  output  24  frame to i2c_controller.
REQ-013 transfer_end  input  1  completion from i2c_controller.
REQ-014 transfer_ack_n  input  1  ACK status from i2c_controller, valid while transfer_end is high; 1 = NACK.

Function
REQ-015 States SHALL be IDLE, XFER and GAP; all outputs SHALL be registered.
REQ-016 IDLE with req nonzero: at the next edge, grant the first set req bit searching upward, wrapping, from (last_grant+1) mod NUM_REQ; set gnt, latch that slot into transfer_data, clear retry count, raise transfer_start, enter XFER.
REQ-017 A request SHALL be granted at the first edge that samples it in IDLE (one-cycle latency).
REQ-018 transfer_data SHALL stay constant from grant until return to IDLE; later req_data changes SHALL be ignored.
REQ-019 XFER: transfer_start SHALL stay high until transfer_end is sampled high; then transfer_start goes low and the state becomes GAP.
REQ-020 On leaving XFER with transfer_ack_n=0, done SHALL pulse on the granted bit for exactly the first GAP cycle.
REQ-021 On leaving XFER with transfer_ack_n=1 and retry count < MAX_RETRY, the retry count SHALL increment, with no done/nack pulse.
REQ-022 On leaving XFER with transfer_ack_n=1 and retry count = MAX_RETRY, nack SHALL pulse on the granted bit for the first GAP cycle.
REQ-023 GAP: hold transfer_start low until transfer_end is sampled low, for a minimum of one cycle.
REQ-024 GAP exit on a pending retry: raise transfer_start with the same transfer_data and re-enter XFER.
REQ-025 GAP exit otherwise: clear gnt, record the granted index as last_grant, enter IDLE.
REQ-026 A MAX_RETRY=3 NACK sequence SHALL therefore produce 4 transfer_start assertions in total.
REQ-027 Deasserting req during XFER/GAP SHALL NOT abort the transfer; done/nack still pulse.
REQ-028 Other requesters' req changes during XFER/GAP SHALL NOT affect the current grant.
REQ-029 A req still high on return to IDLE SHALL be treated as a new request, arbitrated round-robin.
REQ-030 done and nack SHALL never both be high, and never on a non-granted bit.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, gnt=0, done=0, nack=0, busy=0, transfer_start=0, transfer_data=0, retry count=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-032 Reset mid-transfer SHALL drop transfer_start at once and discard the in-flight transfer with no done/nack pulse; the first post-reset grant SHALL follow REQ-016.

Verification (NUM_REQ=4, MAX_RETRY=3)
REQ-033 After reset, req=0100, slot2=24'h341E00, then transfer_end=1 with ack_n=0 -> next edge gnt=0100, transfer_start=1, transfer_data=24'h341E00; done=0100 for one cycle; gnt=0000 once transfer_end=0.
REQ-034 After reset, req=1111, each requester dropping its req on done -> grant order 0001,0010,0100,1000, one done per grant; then req=1001 -> 0001 granted before 1000.
REQ-035 Single requester, transfer_ack_n=1 on every end -> exactly 4 transfer_start rising edges with identical transfer_data, then one nack pulse and no done.
REQ-036 NACK on the first attempt, ACK on the second -> 2 transfer_start rising edges, one done pulse, no nack.
REQ-037 rst_n low during XFER -> transfer_start, gnt and busy read 0 immediately; no done/nack; after release with req held, re-grant at the next edge.
REQ-038 Granted requester drops req mid-XFER -> transfer completes, done pulses, and that requester is not re-granted.
